// File: rtl/output_pkt_scheduler_pkg.sv
// Shared types and helpers for the packet-aware weighted round-robin scheduler.
package output_pkt_scheduler_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] onehot32(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

  function automatic int unsigned weight_sat1(input int unsigned w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping.
module rr_priority_pick #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  int cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(start_i) + i) % N;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/output_pkt_scheduler.sv
// Packet-aware weighted round-robin scheduler sharing one output queue between
// NUM_INPUTS FWFT FIFOs; a grant is held until the last flit of the packet moves.
module output_pkt_scheduler
  import output_pkt_scheduler_pkg::*;
#(
  parameter  int NUM_INPUTS = 5,
  parameter  int DATA_W     = 32,
  parameter  int WEIGHT_W   = 4,
  localparam int PTR_W      = ptr_width(NUM_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_INPUTS-1:0]          fifo_empty_i,
  input  logic [NUM_INPUTS-1:0]          fifo_last_i,
  input  logic [NUM_INPUTS*DATA_W-1:0]   fifo_data_i,
  output logic [NUM_INPUTS-1:0]          fifo_rd_en_o,
  input  logic                           outq_ready_i,
  output logic                           outq_valid_o,
  output logic [DATA_W-1:0]              outq_data_o,
  output logic                           outq_last_o,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] cfg_weight_i,
  output logic                           grant_valid_o,
  output logic                           lock_active_o,
  output logic [PTR_W-1:0]               lock_port_o
);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    cur_port_q, cur_port_d;
  logic [PTR_W-1:0]    lock_port_q, lock_port_d;
  logic                hold_q, hold_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic [PTR_W-1:0]    start_ptr, pick_idx, sel;
  logic                pick_found, hold_ok, sel_avail, fresh, grant;
  logic [WEIGHT_W-1:0] w_sel, fresh_credit, credit_eff;

  assign start_ptr = (rr_ptr_q == PTR_W'(NUM_INPUTS - 1)) ? '0 : rr_ptr_q + 1'b1;

  rr_priority_pick #(.N(NUM_INPUTS), .PW(PTR_W)) u_pick (
    .req_i   (~fifo_empty_i),
    .start_i (start_ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Port selection: locked owner, then held port, then round-robin search.
  always_comb begin
    sel       = lock_port_q;
    sel_avail = 1'b0;
    fresh     = 1'b0;
    hold_ok   = hold_q && !fifo_empty_i[cur_port_q];
    if (state_q == ST_LOCKED) begin
      sel       = lock_port_q;
      sel_avail = !fifo_empty_i[lock_port_q];
    end else if (hold_ok) begin
      sel       = cur_port_q;
      sel_avail = 1'b1;
    end else if (pick_found) begin
      sel       = pick_idx;
      sel_avail = 1'b1;
      fresh     = 1'b1;
    end
  end

  assign grant         = rst_n & outq_ready_i & sel_avail;
  assign grant_valid_o = grant;
  assign outq_valid_o  = grant;
  assign fifo_rd_en_o  = grant ? NUM_INPUTS'(onehot32(32'(sel))) : '0;
  assign outq_data_o   = fifo_data_i[int'(sel)*DATA_W +: DATA_W];
  assign outq_last_o   = fifo_last_i[sel];
  assign lock_active_o = rst_n & (state_q == ST_LOCKED);
  assign lock_port_o   = lock_port_q;

  assign w_sel        = cfg_weight_i[int'(sel)*WEIGHT_W +: WEIGHT_W];
  assign fresh_credit = WEIGHT_W'(weight_sat1(32'(w_sel)));
  assign credit_eff   = fresh ? fresh_credit : credit_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_port_d  = cur_port_q;
    lock_port_d = lock_port_q;
    hold_d      = hold_q;
    credit_d    = credit_q;
    if (state_q == ST_IDLE && hold_q && !hold_ok) hold_d = 1'b0;
    if (grant) begin
      if (fresh) begin
        rr_ptr_d = sel;
        credit_d = fresh_credit;
      end
      if (outq_last_o) begin
        state_d     = ST_IDLE;
        lock_port_d = '0;
        if (credit_eff > WEIGHT_W'(1)) begin
          credit_d   = credit_eff - 1'b1;
          hold_d     = 1'b1;
          cur_port_d = sel;
        end else begin
          credit_d = '0;
          hold_d   = 1'b0;
        end
      end else begin
        state_d     = ST_LOCKED;
        lock_port_d = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cur_port_q  <= '0;
      lock_port_q <= '0;
      hold_q      <= 1'b0;
      credit_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_port_q  <= cur_port_d;
      lock_port_q <= lock_port_d;
      hold_q      <= hold_d;
      credit_q    <= credit_d;
    end
  end

endmodule
